// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI4-Lite response codes, FSM state types and byte-lane merge helper
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}                 rd_state_t;

  // Widest supported word is 64 bits; narrower callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_word;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_strb_ram.sv
// rtl/axi_lite_strb_ram.sv - word array with byte-enable write port and registered, clearable read port
module axi_lite_strb_ram
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Whole array clears on reset; a write only touches the strobed byte lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= DATA_WIDTH'(strb_merge(64'(mem[waddr]), 64'(wdata), 8'(wstrb)));
    end
  end

  // Read register samples the pre-write word on a same-edge collision; it is
  // zeroed when the beat is consumed so the bus data is 0 whenever idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else if (rclr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - AXI4-Lite memory slave, independent read/write FSMs; AXIL_UNALIGNED_SLVERR_EN enables SLVERR on unaligned addresses
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LSB_W = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH * STRB_WIDTH);

  // off = addr - BASE_ADDR; an address below the base wraps to a value past the window.
  function automatic resp_t decode_resp(input logic [ADDR_WIDTH-1:0] off);
    if (off >= WIN_BYTES) return RESP_DECERR;
`ifdef AXIL_UNALIGNED_SLVERR_EN
    if (off[LSB_W-1:0] != '0) return RESP_SLVERR;
`endif
    return RESP_OKAY;
  endfunction

  wr_state_t             w_state;
  rd_state_t             r_state;
  logic                  ready_en;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] c_addr, c_off, r_off;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_WIDTH-1:0] c_strb;
  resp_t                 c_resp, r_resp;

  // Readies stay low from reset assertion until the first edge after release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign AWREADY = ready_en && (w_state == W_IDLE || w_state == W_DATA);
  assign WREADY  = ready_en && (w_state == W_IDLE || w_state == W_ADDR);
  assign ARREADY = ready_en && (r_state == R_IDLE);
  assign BVALID  = (w_state == W_RESP);
  assign RVALID  = (r_state == R_DATA);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // Select the address/data for the commit, taking each from the live bus or its holding register.
  always_comb begin
    wr_commit = 1'b0;
    c_addr    = aw_addr_q;
    c_data    = w_data_q;
    c_strb    = w_strb_q;
    unique case (w_state)
      W_IDLE: begin
        wr_commit = aw_hs && w_hs;
        c_addr    = AWADDR;
        c_data    = WDATA;
        c_strb    = WSTRB;
      end
      W_ADDR: begin
        wr_commit = w_hs;
        c_data    = WDATA;
        c_strb    = WSTRB;
      end
      W_DATA: begin
        wr_commit = aw_hs;
        c_addr    = AWADDR;
      end
      default: ;
    endcase
  end

  assign c_off  = c_addr - BASE_ADDR;
  assign c_resp = decode_resp(c_off);
  assign r_off  = ARADDR - BASE_ADDR;
  assign r_resp = decode_resp(r_off);

  // Write FSM: hold whichever of AW/W arrives first, commit when both are in, then hold B.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BRESP     <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            w_state <= W_RESP;
            BRESP   <= c_resp;
          end else if (aw_hs) begin
            aw_addr_q <= AWADDR;
            w_state   <= W_ADDR;
          end else if (w_hs) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
            w_state  <= W_DATA;
          end
        end
        W_ADDR, W_DATA: begin
          if (wr_commit) begin
            w_state <= W_RESP;
            BRESP   <= c_resp;
          end
        end
        W_RESP: begin
          if (BREADY) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: one outstanding read; response held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      RRESP   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state <= R_DATA;
            RRESP   <= r_resp;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            r_state <= R_IDLE;
            RRESP   <= RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_lite_strb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (ACLK),
    .rst   (ARESET),
    .we    (wr_commit && (c_resp == RESP_OKAY)),
    .waddr (c_off[LSB_W +: IDX_W]),
    .wdata (c_data),
    .wstrb (c_strb),
    .re    (ar_hs && (r_resp == RESP_OKAY)),
    .rclr  (RVALID && RREADY),
    .raddr (r_off[LSB_W +: IDX_W]),
    .rdata (RDATA)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb/tb_axi_lite_mem_slave.sv - randomized self-checking bench for axi_lite_mem_slave against a word-array model
module tb_axi_lite_mem_slave;
  import axi_lite_pkg::*;

  localparam int DEPTH = 32;
  localparam logic [31:0] BASE = 32'h0;

  logic        ACLK, ARESET;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  logic [31:0] model [DEPTH];
  int checks = 0;
  int failures = 0;

  axi_lite_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr);
    if ((addr - BASE) >= 32'(DEPTH * 4)) return RESP_DECERR;
`ifdef AXIL_UNALIGNED_SLVERR_EN
    if (addr[1:0] != 2'b00) return RESP_SLVERR;
`endif
    return RESP_OKAY;
  endfunction

  function automatic int exp_idx(input logic [31:0] addr);
    return int'((addr - BASE) >> 2) % DEPTH;
  endfunction

  // Raise the requested valids at the current negedge; drop each after its handshake edge.
  task automatic do_hs(input bit do_aw, input bit do_w, input bit do_ar, input string tag);
    bit aw_p, w_p, ar_p, hs_aw, hs_w, hs_ar;
    int n;
    aw_p = do_aw; w_p = do_w; ar_p = do_ar;
    AWVALID = aw_p; WVALID = w_p; ARVALID = ar_p;
    n = 0;
    while ((aw_p || w_p || ar_p) && n < 20) begin
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      hs_ar = ARVALID && ARREADY;
      @(posedge ACLK);
      @(negedge ACLK);
      n++;
      if (hs_aw) begin aw_p = 0; AWVALID = 0; end
      if (hs_w)  begin w_p = 0;  WVALID = 0;  end
      if (hs_ar) begin ar_p = 0; ARVALID = 0; end
    end
    check($sformatf("%s_hs_timeout", tag), 64'({aw_p, w_p, ar_p}), 64'(0));
  endtask

  // mode 0: AW+W together, 1: AW then W after gap, 2: W then AW after gap
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int mode, input int gap, input int bp);
    logic [1:0] er;
    bit ok;
    er = exp_resp(addr);
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    if (mode == 0) begin
      do_hs(1, 1, 0, "wr_aw_w");
    end else if (mode == 1) begin
      do_hs(1, 0, 0, "wr_aw");
      repeat (gap) @(negedge ACLK);
      check("hold_aw_rdys", 64'({AWREADY, WREADY, BVALID}), 64'(3'b010));
      do_hs(0, 1, 0, "wr_w");
    end else begin
      do_hs(0, 1, 0, "wr_w");
      repeat (gap) @(negedge ACLK);
      check("hold_w_rdys", 64'({AWREADY, WREADY, BVALID}), 64'(3'b100));
      do_hs(1, 0, 0, "wr_aw");
    end
    check("bvalid_lat", 64'(BVALID), 64'(1));
    check($sformatf("bresp@%h", addr), 64'(BRESP), 64'(er));
    ok = 1;
    repeat (bp) begin
      @(negedge ACLK);
      if (BVALID !== 1'b1 || BRESP !== er) ok = 0;
    end
    if (bp > 0) check("b_stable", 64'(ok), 64'(1));
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    check("b_done", 64'(BVALID), 64'(0));
    if (er == RESP_OKAY) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[exp_idx(addr)][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  task automatic read_txn(input logic [31:0] addr, input int bp);
    logic [1:0]  er;
    logic [31:0] ed;
    bit ok;
    er = exp_resp(addr);
    ed = (er == RESP_OKAY) ? model[exp_idx(addr)] : 32'h0;
    @(negedge ACLK);
    ARADDR = addr;
    do_hs(0, 0, 1, "rd_ar");
    check("rvalid_lat", 64'(RVALID), 64'(1));
    check($sformatf("rresp@%h", addr), 64'(RRESP), 64'(er));
    check($sformatf("rdata@%h", addr), 64'(RDATA), 64'(ed));
    ok = 1;
    repeat (bp) begin
      @(negedge ACLK);
      if (RVALID !== 1'b1 || RRESP !== er || RDATA !== ed) ok = 0;
    end
    if (bp > 0) check("r_stable", 64'(ok), 64'(1));
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    check("r_done", 64'({RVALID, RDATA}), 64'(0));
  endtask

  initial begin
    logic [31:0] old_val, a;
    bit ok;
    ARESET = 1; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
    BREADY = 0; ARADDR = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    repeat (3) @(negedge ACLK);
    check("reset_outs", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}), 64'(0));
    ARESET = 0;

    // directed scenarios
    read_txn(32'h0C, 0);
    write_txn(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    read_txn(32'h04, 0);
    write_txn(32'h04, 32'h12345678, 4'h3, 2, 3, 0);
    read_txn(32'h04, 0);
    write_txn(32'h04, 32'hFFFFFFFF, 4'h0, 1, 1, 0);
    read_txn(32'h04, 0);
    write_txn(32'(DEPTH * 4), 32'hCAFEF00D, 4'hF, 0, 0, 0);
    read_txn(32'(DEPTH * 4), 0);
    read_txn(32'(DEPTH * 4 - 4), 0);
    write_txn(32'h08, 32'h11223344, 4'hF, 1, 0, 5);
    read_txn(32'h08, 5);

    // same-edge read and commit to word 2
    old_val = model[2];
    @(negedge ACLK);
    AWADDR = 32'h08; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; ARADDR = 32'h08;
    check("coll_rdys", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
    do_hs(1, 1, 1, "coll");
    check("coll_bvalid", 64'({BVALID, RVALID}), 64'(2'b11));
    check("coll_rdata_old", 64'(RDATA), 64'(old_val));
    BREADY = 1; RREADY = 1;
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    model[2] = 32'hA5A5A5A5;
    read_txn(32'h08, 0);

    write_txn(32'h06, 32'h0BADF00D, 4'hF, 0, 0, 0);
    read_txn(32'h04, 0);
    read_txn(32'h06, 0);

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(DEPTH * 4) + $urandom_range(0, 255);
        1:       a = $urandom | 32'h8000_0000;
        default: a = $urandom_range(0, DEPTH * 4 - 1);
      endcase
      if ($urandom_range(0, 1) == 0)
        write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        read_txn(a, $urandom_range(0, 3));
    end

    // asynchronous reset while AW is held
    @(negedge ACLK);
    AWADDR = 32'h10;
    do_hs(1, 0, 0, "rst_aw");
    check("pre_rst_waddr", 64'({AWREADY, WREADY}), 64'(2'b01));
    #2 ARESET = 1;
    #1 check("async_rst_outs", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}), 64'(0));
    @(negedge ACLK);
    ARESET = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    ok = 1;
    repeat (5) begin
      @(negedge ACLK);
      if (BVALID !== 1'b0) ok = 0;
    end
    check("no_b_after_rst", 64'(ok), 64'(1));
    for (int i = 0; i < DEPTH; i++) read_txn(32'(i * 4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
